decode_unit: RTL and testbench

DECODE_UNIT -- requirements
Module: decode

---
 rtl/decode_unit.sv | 85 ++++++++
 tb/tb_decode_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/decode_unit.sv
// MIPS decode stage: field extraction, sign extension and register read.
// All outputs are registered; the register file is reset-initialised only.
module decode_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    output logic [5:0]  opcode,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] read_data_1,
    output logic [31:0] read_data_2,
    output logic [31:0] sig_nextended_immediate
);

    logic [31:0] regs_q [32];

    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [31:0] rdata1_d;
    logic [31:0] rdata2_d;
    logic [31:0] imm_d;

    logic [5:0]  opcode_q;
    logic [4:0]  rt_q;
    logic [4:0]  rd_q;
    logic [31:0] rdata1_q;
    logic [31:0] rdata2_q;
    logic [31:0] imm_q;

    assign rs_idx = instruction[25:21];
    assign rt_idx = instruction[20:16];

    // Register file: loaded with its own index on reset, otherwise constant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'(i);
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_q[i];
            end
        end
    end

    // Asynchronous reads with register 0 hardwired to zero, plus sign extension.
    always_comb begin
        rdata1_d = '0;
        rdata2_d = '0;
        if (rs_idx != 5'd0) begin
            rdata1_d = regs_q[rs_idx];
        end
        if (rt_idx != 5'd0) begin
            rdata2_d = regs_q[rt_idx];
        end
        imm_d = {{16{instruction[15]}}, instruction[15:0]};
    end

    // Output capture: one-cycle latency, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
        end else begin
            opcode_q <= instruction[31:26];
            rt_q     <= instruction[20:16];
            rd_q     <= instruction[15:11];
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
        end
    end

    assign opcode                  = opcode_q;
    assign rt                      = rt_q;
    assign rd                      = rd_q;
    assign read_data_1             = rdata1_q;
    assign read_data_2             = rdata2_q;
    assign sig_nextended_immediate = imm_q;

endmodule

// File: tb/tb_decode_unit.sv
// Directed self-checking bench for decode_unit.
// Expected values are hand-decoded instruction fields.
module tb_decode_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [31:0] sig_nextended_immediate;

    int errors = 0;
    int checks = 0;

    decode_unit dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .instruction             (instruction),
        .opcode                  (opcode),
        .rt                      (rt),
        .rd                      (rd),
        .read_data_1             (read_data_1),
        .read_data_2             (read_data_2),
        .sig_nextended_immediate (sig_nextended_immediate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [5:0] e_op,
                           input logic [4:0] e_rt, input logic [4:0] e_rd,
                           input logic [31:0] e_r1, input logic [31:0] e_r2,
                           input logic [31:0] e_imm);
        chk({tag, ".opcode"}, {26'd0, opcode}, {26'd0, e_op});
        chk({tag, ".rt"}, {27'd0, rt}, {27'd0, e_rt});
        chk({tag, ".rd"}, {27'd0, rd}, {27'd0, e_rd});
        chk({tag, ".rd1"}, read_data_1, e_r1);
        chk({tag, ".rd2"}, read_data_2, e_r2);
        chk({tag, ".imm"}, sig_nextended_immediate, e_imm);
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        instruction = 32'h319E_C015;
        #1;
        chk_all("rst_t0", 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk_all("rst_clk", 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        @(negedge clk);
        rst_n       = 1'b1;
        instruction = 32'h0000_0000;
        #1;
        chk_all("rel_hold", 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        edge_then_settle();
        chk_all("zero", 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        @(negedge clk);
        instruction = 32'h319E_C015;
        edge_then_settle();
        chk_all("addi", 6'h0C, 5'd30, 5'd24, 32'd12, 32'd30, 32'hFFFF_C015);

        instruction = 32'hFFFF_FFFF;
        #2;
        chk_all("hold1", 6'h0C, 5'd30, 5'd24, 32'd12, 32'd30, 32'hFFFF_C015);
        @(negedge clk);
        instruction = 32'h8C22_7FFF;
        #2;
        chk_all("hold2", 6'h0C, 5'd30, 5'd24, 32'd12, 32'd30, 32'hFFFF_C015);
        edge_then_settle();
        chk_all("lw", 6'h23, 5'd2, 5'd15, 32'd1, 32'd2, 32'h0000_7FFF);

        @(negedge clk);
        instruction = 32'h00A5_8000;
        edge_then_settle();
        chk_all("rs_eq_rt", 6'h00, 5'd5, 5'd16, 32'd5, 32'd5, 32'hFFFF_8000);

        @(negedge clk);
        instruction = 32'h03FF_0000;
        edge_then_settle();
        chk_all("reg31", 6'h00, 5'd31, 5'd0, 32'd31, 32'd31, 32'd0);

        @(negedge clk);
        instruction = 32'hFFFF_FFFF;
        edge_then_settle();
        chk_all("all_ones", 6'h3F, 5'd31, 5'd31, 32'd31, 32'd31, 32'hFFFF_FFFF);

        @(negedge clk);
        instruction = 32'h319E_C015;
        edge_then_settle();
        chk_all("addi2", 6'h0C, 5'd30, 5'd24, 32'd12, 32'd30, 32'hFFFF_C015);

        #1;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk_all("post_rel", 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        edge_then_settle();
        chk_all("recap", 6'h0C, 5'd30, 5'd24, 32'd12, 32'd30, 32'hFFFF_C015);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
